// File: rtl/vga_timing_gen_if.sv
// Compositor and display bus for vga_timing_gen: raster coordinates out, compositor RGB in,
// aligned VGA video out. The master side is the timing generator.
interface vga_timing_gen_if;
    logic       pix_ce;
    logic [9:0] x_pos;
    logic [9:0] y_pos;
    logic [7:0] red_in;
    logic [7:0] green_in;
    logic [7:0] blue_in;
    logic       test_mode;
    logic [7:0] vga_r;
    logic [7:0] vga_g;
    logic [7:0] vga_b;
    logic       hsync;
    logic       vsync;
    logic       de;
    logic       frame_start;

    modport master (
        output pix_ce, x_pos, y_pos,
        output vga_r, vga_g, vga_b, hsync, vsync, de, frame_start,
        input  red_in, green_in, blue_in, test_mode
    );

    modport slave (
        input  pix_ce, x_pos, y_pos,
        input  vga_r, vga_g, vga_b, hsync, vsync, de, frame_start,
        output red_in, green_in, blue_in, test_mode
    );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator with compositor-latency alignment of RGB, syncs and de.
// Optional colour-bar test pattern when VGA_TEST_PATTERN_EN is defined.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int CLK_DIV  = 2,
    parameter int PIPE_LAT = 2,
    parameter int SYNC_POL = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    vga_timing_gen_if.master bus
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int CW      = 12;
    localparam logic SP    = 1'(SYNC_POL);

    typedef struct packed {
        logic       act;
        logic       hs;
        logic       vs;
        logic [9:0] x;
    } tap_t;

    logic [DIV_W-1:0] div;
    logic             pix_ce;
    logic [CW-1:0]    h_cnt;
    logic [CW-1:0]    v_cnt;
    logic             h_last;
    logic             v_last;
    tap_t             tap_in;
    tap_t             tap_d;
    tap_t             pipe [PIPE_LAT];
    logic [23:0]      rgb_next;
    logic [7:0]       vga_r;
    logic [7:0]       vga_g;
    logic [7:0]       vga_b;
    logic             hsync;
    logic             vsync;
    logic             de;

    // pix_ce is registered from the pre-edge divider value, so the first tick lands two clks after release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div    <= '0;
            pix_ce <= 1'b0;
        end else begin
            pix_ce <= (div == DIV_W'(CLK_DIV - 1));
            if (div == DIV_W'(CLK_DIV - 1))
                div <= '0;
            else
                div <= div + DIV_W'(1);
        end
    end

    assign h_last = (h_cnt == CW'(H_TOTAL - 1));
    assign v_last = (v_cnt == CW'(V_TOTAL - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pix_ce) begin
            if (h_last) begin
                h_cnt <= '0;
                v_cnt <= v_last ? '0 : v_cnt + CW'(1);
            end else begin
                h_cnt <= h_cnt + CW'(1);
            end
        end
    end

    always_comb begin
        tap_in     = '0;
        tap_in.act = (h_cnt < CW'(H_ACTIVE)) && (v_cnt < CW'(V_ACTIVE));
        tap_in.hs  = (h_cnt >= CW'(H_ACTIVE + H_FP)) && (h_cnt < CW'(H_ACTIVE + H_FP + H_SYNC));
        tap_in.vs  = (v_cnt >= CW'(V_ACTIVE + V_FP)) && (v_cnt < CW'(V_ACTIVE + V_FP + V_SYNC));
        tap_in.x   = h_cnt[9:0];
    end

    // Delay line matches the compositor latency; an all-zero tap means blanked and out of sync
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < PIPE_LAT; i++)
                pipe[i] <= '0;
        end else if (pix_ce) begin
            pipe[0] <= tap_in;
            for (int unsigned i = 1; i < PIPE_LAT; i++)
                pipe[i] <= pipe[i-1];
        end
    end

    assign tap_d = pipe[PIPE_LAT-1];

`ifdef VGA_TEST_PATTERN_EN
    logic [2:0]  bar_idx;
    logic [23:0] bar_rgb;

    always_comb begin
        bar_idx = 3'((32'(tap_d.x) * 32'd8) / 32'(H_ACTIVE));
        case (bar_idx)
            3'd0:    bar_rgb = 24'hFFFFFF;
            3'd1:    bar_rgb = 24'hFFFF00;
            3'd2:    bar_rgb = 24'h00FFFF;
            3'd3:    bar_rgb = 24'h00FF00;
            3'd4:    bar_rgb = 24'hFF00FF;
            3'd5:    bar_rgb = 24'hFF0000;
            3'd6:    bar_rgb = 24'h0000FF;
            default: bar_rgb = 24'h000000;
        endcase
    end
`else
    logic unused_ok;
    assign unused_ok = &{1'b0, bus.test_mode, tap_d.x};
`endif

    always_comb begin
        rgb_next = {bus.red_in, bus.green_in, bus.blue_in};
`ifdef VGA_TEST_PATTERN_EN
        if (bus.test_mode)
            rgb_next = bar_rgb;
`endif
        if (!tap_d.act)
            rgb_next = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            de    <= 1'b0;
            hsync <= ~SP;
            vsync <= ~SP;
            vga_r <= '0;
            vga_g <= '0;
            vga_b <= '0;
        end else if (pix_ce) begin
            de    <= tap_d.act;
            hsync <= tap_d.hs ? SP : ~SP;
            vsync <= tap_d.vs ? SP : ~SP;
            {vga_r, vga_g, vga_b} <= rgb_next;
        end
    end

    assign bus.pix_ce      = pix_ce;
    assign bus.x_pos       = h_cnt[9:0];
    assign bus.y_pos       = v_cnt[9:0];
    assign bus.vga_r       = vga_r;
    assign bus.vga_g       = vga_g;
    assign bus.vga_b       = vga_b;
    assign bus.hsync       = hsync;
    assign bus.vsync       = vsync;
    assign bus.de          = de;
    // Counters sit at reset (0,0) after release, so a restart never pulses here
    assign bus.frame_start = pix_ce & h_last & v_last;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed self-checking bench for vga_timing_gen on a reduced 24x10 raster (16x6 active).
// Expected values come from hand-derived tick arithmetic, not from the DUT.
module tb_vga_timing_gen;

    localparam int H_ACTIVE = 16;
    localparam int H_FP     = 2;
    localparam int H_SYNC   = 3;
    localparam int H_BP     = 3;
    localparam int V_ACTIVE = 6;
    localparam int V_FP     = 1;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 1;
    localparam int CLK_DIV  = 2;
    localparam int PIPE_LAT = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vga_timing_gen_if bus ();

    vga_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .CLK_DIV  (CLK_DIV),
        .PIPE_LAT (PIPE_LAT),
        .SYNC_POL (0)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Compositor model: PIPE_LAT registered stages on pix_ce, red = x, green = y, blue = FF
    logic [9:0] cx [PIPE_LAT];
    logic [9:0] cy [PIPE_LAT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < PIPE_LAT; i++) begin
                cx[i] <= '0;
                cy[i] <= '0;
            end
        end else if (bus.pix_ce) begin
            cx[0] <= bus.x_pos;
            cy[0] <= bus.y_pos;
            for (int i = 1; i < PIPE_LAT; i++) begin
                cx[i] <= cx[i-1];
                cy[i] <= cy[i-1];
            end
        end
    end

    assign bus.red_in   = cx[PIPE_LAT-1][7:0];
    assign bus.green_in = cy[PIPE_LAT-1][7:0];
    assign bus.blue_in  = 8'hFF;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    bit tm_phase = 1'b0;
    int fs_cnt  = 0;
    int last_fs = -1;
    int fs_period = 0;
    int de_cnt  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cyc=%0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [23:0] bar_colour(input int idx);
        case (idx)
            0:       return 24'hFFFFFF;
            1:       return 24'hFFFF00;
            2:       return 24'h00FFFF;
            3:       return 24'h00FF00;
            4:       return 24'hFF00FF;
            5:       return 24'hFF0000;
            6:       return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    // {de, hsync, vsync, r, g, b} after n ticks: outputs show raster position n-3
    function automatic logic [26:0] exp_video(input int n, input bit tm);
        int k, h, v;
        bit act, hs_n, vs_n;
        logic [23:0] rgb;
        if (n < 3) return {1'b0, 1'b1, 1'b1, 24'h0};
        k    = n - 3;
        h    = k % 24;
        v    = (k / 24) % 10;
        act  = (h < 16) && (v < 6);
        hs_n = !((h >= 18) && (h < 21));
        vs_n = !((v >= 7) && (v < 9));
        rgb  = act ? {h[7:0], v[7:0], 8'hFF} : 24'h0;
`ifdef VGA_TEST_PATTERN_EN
        if (tm && act) rgb = bar_colour(h / 2);
`else
        if (tm) rgb = rgb;
`endif
        return {act, hs_n, vs_n, rgb};
    endfunction

    task automatic check_reset(input string tag);
        check_eq({tag, "_pix_ce"}, bus.pix_ce, 0);
        check_eq({tag, "_xy"}, {bus.x_pos, bus.y_pos}, 0);
        check_eq({tag, "_fs"}, bus.frame_start, 0);
        check_eq({tag, "_video"}, {bus.de, bus.hsync, bus.vsync, bus.vga_r, bus.vga_g, bus.vga_b},
                 {1'b0, 1'b1, 1'b1, 24'h0});
    endtask

    task automatic run_clocks(input int ncyc);
        int n;
        bit ce;
        repeat (ncyc) begin
            @(negedge clk);
            cyc++;
            n  = (cyc - 1) / 2;
            ce = (cyc >= 2) && (cyc % 2 == 0);
            check_eq("pix_ce", bus.pix_ce, ce);
            check_eq("x_pos", bus.x_pos, n % 24);
            check_eq("y_pos", bus.y_pos, (n / 24) % 10);
            check_eq("frame_start", bus.frame_start, ce && (n % 240 == 239));
            check_eq("video", {bus.de, bus.hsync, bus.vsync, bus.vga_r, bus.vga_g, bus.vga_b},
                     exp_video(n, tm_phase));
            if (bus.frame_start) begin
                fs_cnt++;
                if (last_fs >= 0) fs_period = cyc - last_fs;
                last_fs = cyc;
            end
            if (cyc >= 480 && cyc < 960 && bus.de) de_cnt++;
        end
    endtask

    initial begin
        bus.test_mode = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check_reset("rst_hold");
        end

        // Full raster from release: two frame starts, 480 clk apart
        rst_n = 1'b1;
        cyc   = 0;
        run_clocks(1150);
        check_eq("fs_count", fs_cnt, 2);
        check_eq("fs_period", fs_period, 480);
        check_eq("de_samples_frame", de_cnt, 192);
        check_eq("pre_reset_y", bus.y_pos, 3);

        // Mid-frame reset clears everything at once
        rst_n = 1'b0;
        #1;
        check_reset("rst_mid");
        repeat (2) begin
            @(negedge clk);
            check_reset("rst_mid_hold");
        end
        rst_n   = 1'b1;
        cyc     = 0;
        fs_cnt  = 0;
        last_fs = -1;
        run_clocks(520);
        check_eq("restart_fs_count", fs_cnt, 1);
        check_eq("restart_fs_first", last_fs, 480);

        // Test mode: colour bars with the macro, ignored without it
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset("rst_tm");
        @(negedge clk);
        bus.test_mode = 1'b1;
        tm_phase      = 1'b1;
        rst_n         = 1'b1;
        cyc           = 0;
        run_clocks(300);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
